// File: rtl/cache_plru_state_array.sv
// Tree-PLRU state array with a one-stage read-modify-write pipeline.
// Stage 0 reads a set's PLRU bits, stage 1 presents them to the external
// combinational algorithm and writes the returned bits back on the next edge.
// A flush FSM (IDLE -> DRAIN -> CLEAR) zeroes every set, one per cycle.
module cache_plru_state_array #(
  parameter int WAYS     = 8,
  parameter int WAYS_REP = 3,
  parameter int SETS     = 16384,
  parameter int SET_BITS = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                req_read,
  input  logic                req_hit,
  input  logic [WAYS_REP-1:0] req_hit_way,
  output logic [WAYS-2:0]     plru_to_alg,
  output logic                alg_read,
  output logic                alg_hit,
  output logic [WAYS_REP-1:0] alg_hit_way,
  input  logic [WAYS-2:0]     plru_from_alg,
  input  logic [WAYS_REP-1:0] way_from_alg,
  output logic                rsp_valid,
  output logic [SET_BITS-1:0] rsp_set,
  output logic [WAYS_REP-1:0] rsp_way,
  input  logic                clear_req,
  output logic                busy
);

  localparam int                  PLRU_W   = WAYS - 1;
  localparam logic [1:0]          IDLE     = 2'd0;
  localparam logic [1:0]          DRAIN    = 2'd1;
  localparam logic [1:0]          CLEAR    = 2'd2;
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

  // PLRU payload storage plus one "live" bit per set. A set whose live bit
  // is clear reads as all-zero, which gives reset and flush their zeroing
  // semantics without having to reset the wide payload array.
  logic [PLRU_W-1:0] plru_mem [SETS];
  logic [SETS-1:0]   set_live;

  logic [1:0]          state;
  logic [SET_BITS-1:0] clr_cnt;
  logic                clear_pending;

  logic                s1_valid;
  logic [SET_BITS-1:0] s1_set;
  logic                s1_read;
  logic                s1_hit;
  logic [WAYS_REP-1:0] s1_hit_way;
  logic [PLRU_W-1:0]   s1_plru;

  logic                accept;
  logic [PLRU_W-1:0]   rd_plru;

  assign req_ready = (state == IDLE) && !clear_req && !clear_pending;
  assign accept    = req_valid && req_ready;

  // Read path: array lookup, overridden by the same-edge writeback when the
  // new request targets the set currently in stage 1.
  always_comb begin
    // NOTE: default assignment first so every path drives rd_plru and no latch is inferred.
    rd_plru = set_live[req_set] ? plru_mem[req_set] : '0;
    if (s1_valid && (req_set == s1_set)) begin
      rd_plru = plru_from_alg;
    end
  end

  // Payload writeback from stage 1.
  // NOTE: the payload RAM has no reset; the reset-cleared live bits make its
  // stale contents unobservable, so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      plru_mem[s1_set] <= plru_from_alg;
    end
  end

  // Live bits: set by writeback, cleared by reset or the flush sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_live <= '0;
    end else if (state == CLEAR) begin
      set_live[clr_cnt] <= 1'b0;
    end else if (s1_valid) begin
      set_live[s1_set] <= 1'b1;
    end
  end

  // Stage-1 pipeline registers; hold their last contents while idle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked logic so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_set     <= '0;
      s1_read    <= 1'b0;
      s1_hit     <= 1'b0;
      s1_hit_way <= '0;
      s1_plru    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_set     <= req_set;
        s1_read    <= req_read;
        s1_hit     <= req_hit;
        s1_hit_way <= req_hit_way;
        s1_plru    <= rd_plru;
      end
    end
  end

  // Flush sequencer: drain a pending writeback, then sweep every set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      clear_pending <= 1'b0;
    end else begin
      clear_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state         <= s1_valid ? DRAIN : CLEAR;
            clear_pending <= 1'b1;
          end
        end
        DRAIN: state <= CLEAR;
        CLEAR: begin
          if (clr_cnt == LAST_SET) begin
            clr_cnt <= '0;
            state   <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign plru_to_alg = s1_plru;
  assign alg_read    = s1_read;
  assign alg_hit     = s1_hit;
  assign alg_hit_way = s1_hit_way;
  assign rsp_valid   = s1_valid;
  assign rsp_set     = s1_set;
  assign rsp_way     = way_from_alg;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_cache_plru_state_array.sv
// Self-checking bench for cache_plru_state_array: directed scenarios with
// literal expectations plus randomized traffic, all compared every cycle
// against a set-indexed reference model of the PLRU contents.
module tb_cache_plru_state_array;

  localparam int WAYS     = 8;
  localparam int WAYS_REP = 3;
  localparam int SETS     = 16384;
  localparam int SET_BITS = 14;
  localparam int PW       = WAYS - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [SET_BITS-1:0] req_set = '0;
  logic                req_read = 1'b0;
  logic                req_hit = 1'b0;
  logic [WAYS_REP-1:0] req_hit_way = '0;
  logic [PW-1:0]       plru_to_alg;
  logic                alg_read;
  logic                alg_hit;
  logic [WAYS_REP-1:0] alg_hit_way;
  logic [PW-1:0]       plru_from_alg = '0;
  logic [WAYS_REP-1:0] way_from_alg = '0;
  logic                rsp_valid;
  logic [SET_BITS-1:0] rsp_set;
  logic [WAYS_REP-1:0] rsp_way;
  logic                clear_req = 1'b0;
  logic                busy;

  always #5 clk = ~clk;

  cache_plru_state_array #(
    .WAYS(WAYS), .WAYS_REP(WAYS_REP), .SETS(SETS), .SET_BITS(SET_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .req_read(req_read), .req_hit(req_hit), .req_hit_way(req_hit_way),
    .plru_to_alg(plru_to_alg), .alg_read(alg_read), .alg_hit(alg_hit),
    .alg_hit_way(alg_hit_way), .plru_from_alg(plru_from_alg),
    .way_from_alg(way_from_alg), .rsp_valid(rsp_valid), .rsp_set(rsp_set),
    .rsp_way(rsp_way), .clear_req(clear_req), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the PLRU value each set should hold, the response
  // expected in the current cycle, and how many busy cycles remain.
  logic [PW-1:0]       m_plru [SETS];
  bit                  m_valid;
  logic [SET_BITS-1:0] m_set;
  bit                  m_read;
  bit                  m_hit;
  logic [WAYS_REP-1:0] m_hw;
  logic [PW-1:0]       m_snap;
  int                  m_busy_left;

  task automatic model_reset();
    foreach (m_plru[i]) m_plru[i] = '0;
    m_valid     = 1'b0;
    m_busy_left = 0;
  endtask

  task automatic drive_req(input bit v, input int set, input bit rd, input bit hit,
                           input int hw, input bit clr);
    req_valid   = v;
    req_set     = SET_BITS'(set);
    req_read    = rd;
    req_hit     = hit;
    req_hit_way = WAYS_REP'(hw);
    clear_req   = clr;
  endtask

  task automatic set_alg(input logic [PW-1:0] p, input logic [WAYS_REP-1:0] w);
    plru_from_alg = p;
    way_from_alg  = w;
  endtask

  // One clock cycle: compare outputs with the model, then advance the model
  // across the coming edge. Called just after a falling edge with inputs set.
  task automatic cycle();
    bit acc;
    bit exp_ready;
    #1;
    exp_ready = (m_busy_left == 0) && !clear_req;
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy_left > 0));
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (m_valid) begin
      check("plru_to_alg", 32'(plru_to_alg), 32'(m_snap));
      check("rsp_set", 32'(rsp_set), 32'(m_set));
      check("alg_read", 32'(alg_read), 32'(m_read));
      check("alg_hit", 32'(alg_hit), 32'(m_hit));
      check("alg_hit_way", 32'(alg_hit_way), 32'(m_hw));
      check("rsp_way", 32'(rsp_way), 32'(way_from_alg));
    end
    acc = req_valid && exp_ready;
    // The returned bits become the set's value before any same-edge read.
    if (m_valid) m_plru[m_set] = plru_from_alg;
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (clear_req) begin
      m_busy_left = SETS + (m_valid ? 1 : 0);
      foreach (m_plru[i]) m_plru[i] = '0;
    end
    m_valid = acc;
    if (acc) begin
      m_set  = req_set;
      m_read = req_read;
      m_hit  = req_hit;
      m_hw   = req_hit_way;
      m_snap = m_plru[req_set];
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive_req(0, 0, 0, 0, 0, 0);
    set_alg(PW'($urandom), WAYS_REP'($urandom));
    cycle();
  endtask

  initial begin
    int busy_cnt;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_plru_to_alg", 32'(plru_to_alg), 32'd0);
    check("reset_rsp_set", 32'(rsp_set), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Read of set 5 after reset returns zero, response lasts one cycle.
    drive_req(1, 5, 1, 0, 0, 0); set_alg(7'h2a, 3'd1); cycle();
    drive_req(0, 0, 0, 0, 0, 0); set_alg(7'h00, 3'd0);
    check("t1_snap_zero", 32'(plru_to_alg), 32'd0);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_set", 32'(rsp_set), 32'd5);
    cycle();
    check("t1_rsp_drop", 32'(rsp_valid), 32'd0);

    // Writeback of set 5 and re-read three cycles later.
    drive_req(1, 5, 0, 0, 0, 0); set_alg(7'h00, 3'd0); cycle();
    drive_req(0, 0, 0, 0, 0, 0); set_alg(7'b1010011, 3'd3);
    #1 check("t2_rsp_way", 32'(rsp_way), 32'd3);
    cycle();
    idle_cycle();
    drive_req(1, 5, 0, 0, 0, 0); cycle();
    drive_req(0, 0, 0, 0, 0, 0); set_alg(7'h0f, 3'd2);
    #1 check("t2_second_snap", 32'(plru_to_alg), 32'b1010011);
    cycle();

    // Back-to-back same-set accesses exercise forwarding; set 10 unaffected.
    drive_req(1, 9, 0, 0, 0, 0); set_alg(7'h00, 3'd0); cycle();
    drive_req(1, 9, 0, 0, 0, 0); set_alg(7'b0001011, 3'd4); cycle();
    drive_req(1, 10, 0, 0, 0, 0); set_alg(7'b1111000, 3'd5);
    #1 check("t3_forward", 32'(plru_to_alg), 32'b0001011);
    cycle();
    drive_req(0, 0, 0, 0, 0, 0); set_alg(7'h55, 3'd0);
    #1 check("t3_set10_zero", 32'(plru_to_alg), 32'd0);
    cycle();
    drive_req(1, 9, 0, 0, 0, 0); cycle();
    drive_req(0, 0, 0, 0, 0, 0);
    #1 check("t3_set9_final", 32'(plru_to_alg), 32'b1111000);
    cycle();

    // Hit information passes through stage 1.
    drive_req(1, 33, 1, 1, 6, 0); cycle();
    drive_req(0, 0, 0, 0, 0, 0); set_alg(7'h3c, 3'd6);
    #1;
    check("t4_alg_read", 32'(alg_read), 32'd1);
    check("t4_alg_hit", 32'(alg_hit), 32'd1);
    check("t4_alg_hit_way", 32'(alg_hit_way), 32'd6);
    check("t4_rsp_way", 32'(rsp_way), 32'd6);
    cycle();

    // Populate sets 0, 100, SETS-1, then flush while set 100 is in stage 1.
    drive_req(1, 0, 0, 0, 0, 0); cycle();
    drive_req(1, 100, 0, 0, 0, 0); set_alg(7'h11, 3'd1); cycle();
    drive_req(1, SETS-1, 0, 0, 0, 0); set_alg(7'h22, 3'd2); cycle();
    drive_req(1, 100, 0, 0, 0, 0); set_alg(7'h33, 3'd3); cycle();
    drive_req(1, 0, 0, 0, 0, 1); set_alg(7'h44, 3'd4);
    #1 check("t5_clear_wins", 32'(req_ready), 32'd0);
    cycle();
    clear_req = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < SETS + 8; i++) begin
      if (!busy) break;
      busy_cnt++;
      cycle();
    end
    check("t5_busy_cycles", 32'(busy_cnt), 32'(SETS + 1));
    cycle();  // held request for set 0 accepted on first idle cycle
    drive_req(1, 100, 0, 0, 0, 0); set_alg(7'h66, 3'd0);
    #1 check("t5_set0_zero", 32'(plru_to_alg), 32'd0);
    cycle();
    drive_req(1, SETS-1, 0, 0, 0, 0); set_alg(7'h5a, 3'd0);
    #1 check("t5_set100_zero", 32'(plru_to_alg), 32'd0);
    cycle();
    drive_req(0, 0, 0, 0, 0, 0); set_alg(7'h77, 3'd0);
    #1 check("t5_setlast_zero", 32'(plru_to_alg), 32'd0);
    cycle();

    // Reset during the clear sweep (counter at 50) aborts it at once.
    drive_req(0, 0, 0, 0, 0, 1); cycle();
    clear_req = 1'b0;
    repeat (50) cycle();
    #2 rst = 1'b1;
    #1;
    check("t6_busy_in_reset", 32'(busy), 32'd0);
    check("t6_rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_req(1, 100, 0, 0, 0, 0);
    #1 check("t6_ready_after_reset", 32'(req_ready), 32'd1);
    cycle();
    drive_req(0, 0, 0, 0, 0, 0);
    #1 check("t6_set100_zero", 32'(plru_to_alg), 32'd0);
    cycle();

    // Randomized traffic concentrated on a few sets to provoke forwarding.
    for (int n = 0; n < 3000; n++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SETS-1))
                                      : int'($urandom_range(0, 7));
      drive_req(($urandom_range(0, 3) != 0), s, 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 7)), 1'b0);
      set_alg(PW'($urandom), WAYS_REP'($urandom));
      cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_plru_state_array.md
Name: cache_plru_state_array

Overview:
Per-set storage and read-modify-write sequencer for the tree-PLRU bits consumed and produced by the combinational replacement algorithm stage. Accepts one cache-set access per cycle and presents that set's current PLRU bits plus the hit information to the algorithm stage. Captures the updated bits and chosen way back, writes them into the array, and reports the way. Also provides a multi-cycle flush that zeroes every set's PLRU state.

Parameters:
WAYS, 8, associativity; PLRU width is WAYS-1
WAYS_REP, 3, bits to encode a way (log2 WAYS)
SETS, 16384, number of sets stored
SET_BITS, 14, set index width (log2 SETS)

Ports:
clk  input  1  clock; all state rises on posedge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  access request present
req_ready  output  1  block can accept a request this cycle
req_set  input  SET_BITS  set index of the access
req_read  input  1  access is a read
req_hit  input  1  tag compare hit
req_hit_way  input  WAYS_REP  way that hit
plru_to_alg  output  WAYS-1  stage-1 PLRU snapshot driven to the algorithm stage
alg_read  output  1  stage-1 copy of req_read
alg_hit  output  1  stage-1 copy of req_hit
alg_hit_way  output  WAYS_REP  stage-1 copy of req_hit_way
plru_from_alg  input  WAYS-1  updated PLRU bits returned by the algorithm stage (combinational, same cycle)
way_from_alg  input  WAYS_REP  way chosen by the algorithm stage (combinational, same cycle)
rsp_valid  output  1  response valid (equals stage-1 valid)
rsp_set  output  SET_BITS  set of the response
rsp_way  output  WAYS_REP  selected/hit way (passes way_from_alg)
clear_req  input  1  single-cycle pulse: flush all PLRU state
busy  output  1  flush in progress (FSM not IDLE)

Behaviour:
- Reset (async, rst=1): every array entry = 0; s1_valid=0; s1 regs = 0; FSM=IDLE; clr_cnt=0; clear_pending=0. Outputs: req_ready=1 once rst deasserts. rsp_valid=0, busy=0, plru_to_alg=0, alg_*=0, rsp_set=0. Reset mid-flush or mid-access aborts it immediately with no partial writeback.
- Handshake: a request is accepted on a posedge where req_valid && req_ready. req_ready = (FSM==IDLE) && !clear_req && !clear_pending.
- Stage 1 (cycle after accept): s1_valid=1. s1_set, s1_read, s1_hit, s1_hit_way are registered. s1_plru = array[req_set] at accept edge. Outputs drive these registers directly. rsp_valid=s1_valid, rsp_set=s1_set, rsp_way=way_from_alg. Latency accept→response = 1 cycle.
- Writeback: on every posedge with s1_valid=1, array[s1_set] <= plru_from_alg. s1_valid drops unless a new request is accepted on that same edge. Sustained throughput: 1 access/cycle.
- Forwarding: if a request is accepted on the same edge that writes back and req_set==s1_set, the new s1_plru = plru_from_alg, not the stale array value. Different sets read the array normally.
- Flush FSM, states IDLE, DRAIN, CLEAR:
  - IDLE: clear_req=1 → DRAIN if s1_valid, else CLEAR. clear_req while busy is ignored.
  - DRAIN: 1 cycle. Pending writeback completes; no new accept. → CLEAR.
  - CLEAR: each cycle array[clr_cnt] <= 0, clr_cnt++. When clr_cnt==SETS-1, that set is written, clr_cnt <= 0, → IDLE. Flush takes SETS cycles in CLEAR.
- busy = FSM!=IDLE. req_ready=0 throughout DRAIN/CLEAR. Requests held by the upstream are accepted on the first IDLE cycle.
- clear_req and req_valid asserted in the same cycle: the clear wins and the request is not accepted.
- Widths: set index is not range-checked; SETS must equal 2**SET_BITS. No arithmetic beyond the counter wrap at SETS-1.

Test Plan:
- Reset, then read set 5 → plru_to_alg=7'b0000000 one cycle after accept, rsp_valid=1 for exactly 1 cycle, rsp_set=5.
- Access set 5 with bench algorithm returning plru_from_alg=7'b1010011, way_from_alg=3. Access set 5 again 3 cycles later → rsp_way=3 on the first response; second snapshot plru_to_alg=7'b1010011.
- Back-to-back accepts on set 9, alg returns 7'b0001011 then 7'b1111000 → second snapshot equals 7'b0001011 via forwarding. Array[9] ends 7'b1111000. Interleave set 10 and check it still reads 0.
- Hit pass-through: req_read=1, req_hit=1, req_hit_way=6 → alg_read=1, alg_hit=1, alg_hit_way=6 in stage 1. Bench returns way 6 → rsp_way=6.
- Write nonzero PLRU to sets 0, 100, SETS-1, then pulse clear_req while set 100 is in stage 1 → DRAIN 1 cycle, busy high for 1+SETS cycles, req_ready low, then all three sets read 7'b0000000.
- Assert rst during CLEAR at clr_cnt=50 → busy=0 and rsp_valid=0 immediately; after release any set reads 0 and req_ready=1.
